led_phase_scheduler: RTL and testbench

Sequences a bank of four LED outputs from one shared period counter, placing each LED's on-window in quarter-period slots. It replaces per-LED free-running timing modules with one scheduler. Mode changes arrive on a valid/ready handshake and take effect only at a period boundary, so no partial or glitched window is ever emitted. It sits between the board-control logic (enable, mode) and the LED pins.

---
 rtl/led_phase_scheduler.sv | 179 +++++++++++++++++
 tb/tb_led_phase_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_phase_scheduler.sv
// Four-LED phase scheduler: one shared period counter drives chase, blink and
// ping-pong patterns; mode changes are deferred to a period boundary.
module led_phase_scheduler #(
    parameter int PERIOD = 2_000_000,
    parameter int CW     = 21
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       En,
    input  logic [1:0] Mode_In,
    input  logic       Mode_Valid,
    output logic       Mode_Ready,
    output logic [3:0] LED_Out,
    output logic       Period_Tick,
    output logic       Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } state_t;

    localparam logic [CW-1:0] LAST_C = CW'(PERIOD - 1);
    localparam logic [CW-1:0] Q1_C   = CW'(PERIOD / 4);
    localparam logic [CW-1:0] Q2_C   = CW'(PERIOD / 2);
    localparam logic [CW-1:0] Q3_C   = CW'(3 * (PERIOD / 4));
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    state_t          state_r, state_s;
    logic [CW-1:0]   count_r, count_s;
    logic            wrap_s;
    logic            accept_s, apply_s;
    logic [1:0]      cur_mode_r, cur_mode_s;
    logic [1:0]      pend_mode_r, pend_mode_s;
    logic            pend_valid_r, pend_valid_s;
    logic [2:0]      step_r, step_s;
    logic [1:0]      qi_s, pos_s;
    logic [3:0]      led_s;
    logic            mode_ready_r;
    logic [3:0]      led_r;
    logic            tick_r;
    logic            busy_r;

    assign wrap_s   = (state_r != ST_IDLE) && (count_r == LAST_C);
    assign accept_s = Mode_Valid && !pend_valid_r;
    // A pending mode lands immediately in IDLE, otherwise only on the wrap cycle.
    assign apply_s  = pend_valid_r && ((state_r == ST_IDLE) || wrap_s);

    // Next-state and period counter.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                count_s = '0;
                if (En) state_s = ST_RUN;
                else    state_s = ST_IDLE;
            end
            ST_RUN: begin
                count_s = wrap_s ? '0 : count_r + ONE_C;
                if (!En) state_s = ST_STOP;
                else     state_s = ST_RUN;
            end
            ST_STOP: begin
                count_s = wrap_s ? '0 : count_r + ONE_C;
                if (En)          state_s = ST_RUN;
                else if (wrap_s) state_s = ST_IDLE;
                else             state_s = ST_STOP;
            end
            default: begin
                state_s = ST_IDLE;
                count_s = '0;
            end
        endcase
    end

    // Mode handshake, pending slot and step counter.
    always_comb begin
        pend_valid_s = pend_valid_r;
        pend_mode_s  = pend_mode_r;
        cur_mode_s   = cur_mode_r;
        step_s       = step_r;
        if (apply_s) begin
            pend_valid_s = 1'b0;
            cur_mode_s   = pend_mode_r;
            step_s       = 3'd0;
        end else if (accept_s) begin
            pend_valid_s = 1'b1;
            pend_mode_s  = Mode_In;
        end else begin
            pend_valid_s = pend_valid_r;
        end
        if (!apply_s && wrap_s) begin
            if (step_r == 3'd5) step_s = 3'd0;
            else                step_s = step_r + 3'd1;
        end else begin
            step_s = step_s;
        end
    end

    // Quarter index, ping-pong position and LED pattern decode.
    always_comb begin
        if (count_r >= Q3_C)      qi_s = 2'd3;
        else if (count_r >= Q2_C) qi_s = 2'd2;
        else if (count_r >= Q1_C) qi_s = 2'd1;
        else                      qi_s = 2'd0;

        case (step_r)
            3'd0:    pos_s = 2'd0;
            3'd1:    pos_s = 2'd1;
            3'd2:    pos_s = 2'd2;
            3'd3:    pos_s = 2'd3;
            3'd4:    pos_s = 2'd2;
            3'd5:    pos_s = 2'd1;
            default: pos_s = 2'd0;
        endcase

        led_s = 4'b0000;
        if (state_r == ST_IDLE) begin
            led_s = 4'b0000;
        end else begin
            case (cur_mode_r)
                2'b00:   led_s = 4'b0000;
                2'b01:   led_s = 4'b0001 << qi_s;
                2'b10:   led_s = (qi_s == 2'd3) ? 4'b1111 : 4'b0000;
                2'b11:   led_s = 4'b0001 << pos_s;
                default: led_s = 4'b0000;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            count_r <= '0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Mode and step registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_mode_r   <= 2'b00;
            pend_mode_r  <= 2'b00;
            pend_valid_r <= 1'b0;
            step_r       <= 3'd0;
        end else begin
            cur_mode_r   <= cur_mode_s;
            pend_mode_r  <= pend_mode_s;
            pend_valid_r <= pend_valid_s;
            step_r       <= step_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_ready_r <= 1'b1;
            led_r        <= 4'b0000;
            tick_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            mode_ready_r <= !pend_valid_s;
            led_r        <= led_s;
            tick_r       <= wrap_s;
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign Mode_Ready  = mode_ready_r;
    assign LED_Out     = led_r;
    assign Period_Tick = tick_r;
    assign Busy        = busy_r;

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Directed bench for led_phase_scheduler with PERIOD=16 (Q=4); expected
// patterns are derived from the count value preceding each sampled edge.
module tb_led_phase_scheduler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       En;
    logic [1:0] Mode_In;
    logic       Mode_Valid;
    logic       Mode_Ready;
    logic [3:0] LED_Out;
    logic       Period_Tick;
    logic       Busy;

    int total = 0;
    int bad   = 0;
    int pp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    led_phase_scheduler #(.PERIOD(16), .CW(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .En(En),
        .Mode_In(Mode_In),
        .Mode_Valid(Mode_Valid),
        .Mode_Ready(Mode_Ready),
        .LED_Out(LED_Out),
        .Period_Tick(Period_Tick),
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] onehot_f(input int idx);
        logic [3:0] v;
        v = 4'b0001;
        return v << idx;
    endfunction

    function automatic logic [3:0] chase_f(input int c);
        return onehot_f(c / 4);
    endfunction

    function automatic logic [3:0] blink_f(input int c);
        return (c >= 12) ? 4'b1111 : 4'b0000;
    endfunction

    initial begin
        RST = 1'b1; En = 1'b0; Mode_Valid = 1'b0; Mode_In = 2'b00;
        #2;
        chk("rst_led",   LED_Out, 4'b0000);
        chk("rst_busy",  {3'b000, Busy}, 4'd0);
        chk("rst_ready", {3'b000, Mode_Ready}, 4'd1);
        chk("rst_tick",  {3'b000, Period_Tick}, 4'd0);
        cyc(); cyc();
        RST = 1'b0;
        cyc();
        chk("idle_led", LED_Out, 4'b0000);

        // Chase: mode accepted in IDLE, then run three periods
        Mode_In = 2'b01; Mode_Valid = 1'b1;
        cyc();
        chk("acc_ready_low", {3'b000, Mode_Ready}, 4'd0);
        Mode_Valid = 1'b0;
        cyc(); cyc();
        chk("idle_ready_back", {3'b000, Mode_Ready}, 4'd1);
        chk("idle_led2", LED_Out, 4'b0000);
        chk("idle_busy", {3'b000, Busy}, 4'd0);
        En = 1'b1;
        cyc();
        chk("entry_busy", {3'b000, Busy}, 4'd1);
        chk("entry_led",  LED_Out, 4'b0000);
        chk("entry_tick", {3'b000, Period_Tick}, 4'd0);
        for (int i = 1; i <= 48; i++) begin
            cyc();
            chk("chase_led",  LED_Out, chase_f((i - 1) % 16));
            chk("chase_tick", {3'b000, Period_Tick}, (i % 16 == 0) ? 4'd1 : 4'd0);
        end

        // Boundary change: request blink at Count=5
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("chase_pre", LED_Out, chase_f(c));
        end
        Mode_In = 2'b10; Mode_Valid = 1'b1;
        cyc();
        chk("bnd_led5", LED_Out, chase_f(5));
        chk("bnd_ready_low", {3'b000, Mode_Ready}, 4'd0);
        Mode_Valid = 1'b0;
        for (int c = 6; c <= 15; c++) begin
            cyc();
            chk("bnd_chase_led", LED_Out, chase_f(c));
            chk("bnd_ready", {3'b000, Mode_Ready}, (c == 15) ? 4'd1 : 4'd0);
        end
        for (int i = 0; i < 48; i++) begin
            cyc();
            chk("blink_led", LED_Out, blink_f(i % 16));
        end

        // Request ping-pong on the Count=15 cycle: deferred one period
        for (int c = 0; c < 15; c++) begin
            cyc();
            chk("blink_pre", LED_Out, blink_f(c));
        end
        Mode_In = 2'b11; Mode_Valid = 1'b1;
        cyc();
        chk("defer_led15", LED_Out, 4'b1111);
        chk("defer_ready_low", {3'b000, Mode_Ready}, 4'd0);
        Mode_Valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cyc();
            chk("defer_led", LED_Out, blink_f(c));
        end
        chk("defer_ready_back", {3'b000, Mode_Ready}, 4'd1);
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 16; c++) begin
                cyc();
                chk("pp_led", LED_Out, onehot_f(pp[p]));
            end
        end

        // Stop: En drops at Count=3, period completes, then IDLE
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("stop_pre_led", LED_Out, 4'b0100);
        end
        En = 1'b0;
        cyc();
        chk("stop_led3", LED_Out, 4'b0100);
        for (int c = 4; c <= 14; c++) begin
            cyc();
            chk("stop_led",  LED_Out, 4'b0100);
            chk("stop_busy", {3'b000, Busy}, 4'd1);
        end
        cyc();
        chk("stop_end_busy", {3'b000, Busy}, 4'd0);
        chk("stop_end_led",  LED_Out, 4'b0100);
        cyc();
        chk("stop_idle_led", LED_Out, 4'b0000);
        cyc();
        chk("stop_idle_busy", {3'b000, Busy}, 4'd0);
        chk("stop_idle_led2", LED_Out, 4'b0000);

        // Stop then resume at Count=10: no Count discontinuity
        En = 1'b1;
        cyc();
        chk("resume_busy", {3'b000, Busy}, 4'd1);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("resume_led", LED_Out, 4'b1000);
        end
        En = 1'b0;
        cyc();
        chk("resume_led3", LED_Out, 4'b1000);
        for (int c = 4; c <= 9; c++) begin
            cyc();
            chk("resume_stop_led", LED_Out, 4'b1000);
            chk("resume_stop_busy", {3'b000, Busy}, 4'd1);
        end
        En = 1'b1;
        cyc();
        chk("resume_led10", LED_Out, 4'b1000);
        for (int c = 11; c <= 15; c++) begin
            cyc();
            chk("resume_tick", {3'b000, Period_Tick}, (c == 15) ? 4'd1 : 4'd0);
            chk("resume_busy2", {3'b000, Busy}, 4'd1);
        end
        for (int c = 0; c <= 15; c++) begin
            cyc();
            chk("resume_next_led",  LED_Out, 4'b0100);
            chk("resume_next_tick", {3'b000, Period_Tick}, (c == 15) ? 4'd1 : 4'd0);
        end

        // Reset mid-run with a mode pending
        Mode_In = 2'b01; Mode_Valid = 1'b1;
        cyc();
        chk("rst2_acc_ready", {3'b000, Mode_Ready}, 4'd0);
        Mode_Valid = 1'b0;
        cyc(); cyc();
        #2;
        RST = 1'b1; En = 1'b0;
        #1;
        chk("rst2_led",   LED_Out, 4'b0000);
        chk("rst2_busy",  {3'b000, Busy}, 4'd0);
        chk("rst2_ready", {3'b000, Mode_Ready}, 4'd1);
        chk("rst2_tick",  {3'b000, Period_Tick}, 4'd0);
        cyc();
        RST = 1'b0;
        cyc(); cyc();
        En = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("rst2_no_stale", LED_Out, 4'b0000);
        end
        chk("rst2_run_busy",  {3'b000, Busy}, 4'd1);
        chk("rst2_run_ready", {3'b000, Mode_Ready}, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
